// File: rtl/buff_rd_ctrl.sv
// buff_rd_ctrl: host-side read port for the GEMM on-chip buffers.
// Decodes a byte address to IMEM/WMEM/OMEM, issues a one-cycle SRAM read,
// slices the 32-bit bank word and returns it through a small response FIFO.
module buff_rd_ctrl #(
  parameter int BUFF_ADDR_WIDTH = 14,
  parameter int BUFF_DATA_WIDTH = 32,
  parameter int IMEM_ADDR_WIDTH = 6,
  parameter int WMEM_ADDR_WIDTH = 6,
  parameter int OMEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH  = 512,
  parameter int RSP_DEPTH       = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  input  logic [BUFF_ADDR_WIDTH-1:0] rd_req_addr,
  output logic                       rd_rsp_valid,
  input  logic                       rd_rsp_ready,
  output logic [BUFF_DATA_WIDTH-1:0] rd_rsp_data,
  output logic                       rd_rsp_err,
  output logic                       imem_rd_en,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_rd_addr,
  input  logic [MEM_DATA_WIDTH-1:0]  imem_rd_data,
  output logic                       wmem_rd_en,
  output logic [WMEM_ADDR_WIDTH-1:0] wmem_rd_addr,
  input  logic [MEM_DATA_WIDTH-1:0]  wmem_rd_data,
  output logic                       omem_rd_en,
  output logic [OMEM_ADDR_WIDTH-1:0] omem_rd_addr,
  input  logic [BUFF_DATA_WIDTH-1:0] omem_rd_data,
  output logic [15:0]                err_cnt
);

  localparam int BANK_W = $clog2(MEM_DATA_WIDTH / BUFF_DATA_WIDTH);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  typedef enum logic [1:0] {
    SEL_IMEM = 2'd0,
    SEL_WMEM = 2'd1,
    SEL_OMEM = 2'd2,
    SEL_ERR  = 2'd3
  } sel_t;

  sel_t                       req_sel;
  logic [BANK_W-1:0]          req_bank;
  logic                       acc;
  logic                       pop;
  logic                       push;
  logic [CNT_W:0]             outstanding;

  logic                       infl_valid;
  sel_t                       infl_sel;
  logic [BANK_W-1:0]          infl_bank;

  logic [BUFF_DATA_WIDTH-1:0] push_data;
  logic                       push_err;

  logic [BUFF_DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic                       fifo_err  [RSP_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;

  logic                       unused_addr_bits;

  // The two lowest address bits select a byte within the word and are not used.
  assign unused_addr_bits = &{1'b0, rd_req_addr[1:0]};

  assign req_sel  = sel_t'(rd_req_addr[BUFF_ADDR_WIDTH-1 -: 2]);
  assign req_bank = rd_req_addr[2 +: BANK_W];

  assign outstanding  = {1'b0, count} + (CNT_W + 1)'(infl_valid);
  assign rd_rsp_valid = (count != '0);
  assign pop          = rd_rsp_valid && rd_rsp_ready;
  assign rd_req_ready = (outstanding < (CNT_W + 1)'(RSP_DEPTH)) || pop;
  assign acc          = rd_req_valid && rd_req_ready;
  assign push         = infl_valid;

  assign rd_rsp_data = rd_rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rd_rsp_err  = rd_rsp_valid ? fifo_err[rd_ptr] : 1'b0;

  // Decode the request into per-memory read strobes; at most one fires per accept.
  always_comb begin
    imem_rd_en   = acc && (req_sel == SEL_IMEM);
    wmem_rd_en   = acc && (req_sel == SEL_WMEM);
    omem_rd_en   = acc && (req_sel == SEL_OMEM);
    imem_rd_addr = rd_req_addr[2 + BANK_W +: IMEM_ADDR_WIDTH];
    wmem_rd_addr = rd_req_addr[2 + BANK_W +: WMEM_ADDR_WIDTH];
    omem_rd_addr = rd_req_addr[2 +: OMEM_ADDR_WIDTH];
  end

  // Remember which memory and bank the read went to, so the returning row can be sliced.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      infl_valid <= 1'b0;
      infl_sel   <= SEL_IMEM;
      infl_bank  <= '0;
    end else begin
      infl_valid <= acc;
      if (acc) begin
        infl_sel  <= req_sel;
        infl_bank <= req_bank;
      end
    end
  end

  // Pick the 32-bit word out of whatever the memory returned this cycle.
  always_comb begin
    push_data = '0;
    push_err  = 1'b0;
    case (infl_sel)
      SEL_IMEM: push_data = imem_rd_data[int'(infl_bank) * BUFF_DATA_WIDTH +: BUFF_DATA_WIDTH];
      SEL_WMEM: push_data = wmem_rd_data[int'(infl_bank) * BUFF_DATA_WIDTH +: BUFF_DATA_WIDTH];
      SEL_OMEM: push_data = omem_rd_data;
      default:  push_err  = 1'b1;
    endcase
  end

  // Response FIFO; occupancy never exceeds depth because acceptance is gated on it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_err[wr_ptr]  <= push_err;
        wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Count consumed error responses, sticking at the maximum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (pop && rd_rsp_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: doc/buff_rd_ctrl.md
Name: buff_rd_ctrl

Overview:
- Host-side read port for the GEMM kernel's on-chip buffers.
- Accepts 32-bit-word read requests on the 14-bit buffer byte-address space and decodes each address to input, weight or output memory, plus bank and word address.
- Issues a 1-cycle-latency SRAM read, selects the 32-bit bank slice, and returns it over a valid/ready response channel with a small response FIFO.
- Complements the buffer write path; used to read back OMEM results and to check IMEM/WMEM contents.

Parameters:
- BUFF_ADDR_WIDTH, 14: byte-address width of the buffer space.
- BUFF_DATA_WIDTH, 32: response data width.
- IMEM_ADDR_WIDTH, 6: input memory word-address width.
- WMEM_ADDR_WIDTH, 6: weight memory word-address width.
- OMEM_ADDR_WIDTH, 10: output memory word-address width.
- MEM_DATA_WIDTH, 512: IMEM/WMEM row width (16 banks x 32).
- RSP_DEPTH, 2: maximum outstanding reads (in-flight plus queued).

Ports:
- clk  in  1  kernel clock.
- rstn  in  1  asynchronous active-low reset.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  request accepted when valid && ready.
- rd_req_addr  in  14  byte address; bits [1:0] ignored.
- rd_rsp_valid  out  1  response valid.
- rd_rsp_ready  in  1  response consumed when valid && ready.
- rd_rsp_data  out  32  read data.
- rd_rsp_err  out  1  decode error on this response.
- imem_rd_en  out  1  IMEM read enable.
- imem_rd_addr  out  6  IMEM row address.
- imem_rd_data  in  512  IMEM row data, valid the cycle after en.
- wmem_rd_en  out  1  WMEM read enable.
- wmem_rd_addr  out  6  WMEM row address.
- wmem_rd_data  in  512  WMEM row data, valid the cycle after en.
- omem_rd_en  out  1  OMEM read enable.
- omem_rd_addr  out  10  OMEM word address.
- omem_rd_data  in  32  OMEM data, valid the cycle after en.
- err_cnt  out  16  saturating count of decode-error responses.

Behaviour:
- Address decode, sel = addr[13:12]:
  - sel 0 (IMEM): bank = addr[5:2], row = addr[11:6].
  - sel 1 (WMEM): bank = addr[5:2], row = addr[11:6].
  - sel 2 (OMEM): word = addr[11:2].
  - sel 3: decode error.
- Accept rule: acc = rd_req_valid && rd_req_ready, where rd_req_ready = (outstanding < RSP_DEPTH) || (rd_rsp_valid && rd_rsp_ready).
  - outstanding = in-flight stage count (0/1) + FIFO occupancy.
- Cycle T (acc):
  - Exactly one of imem/wmem/omem_rd_en pulses high, combinationally from acc; addresses are driven from the decode.
  - sel 3 asserts no enable.
  - sel and bank are registered into the in-flight stage.
  - Enables are 0 in every non-accept cycle.
- Cycle T+1: in-flight stage selects data.
  - IMEM/WMEM: row[bank*32 +: 32].
  - OMEM: omem_rd_data.
  - sel 3: data 0, err 1.
  - {data, err} is pushed into the FIFO at the T+1 edge.
- Cycle T+2: rd_rsp_valid = 1 when FIFO non-empty.
  - Head data/err are held stable while valid && !ready.
- Load-to-use latency is 2 cycles. Back-to-back throughput is 1/cycle with rd_rsp_ready held high.
- Responses return strictly in request order.
- Push and pop in the same cycle on a non-empty FIFO are legal; occupancy is unchanged.
- The FIFO never overflows by construction, since outstanding is always <= RSP_DEPTH.
- err_cnt increments on each error response pop (valid && ready && err) and saturates at 16'hFFFF.
- Reset (asynchronous, any time):
  - FIFO emptied; in-flight stage cleared; err_cnt = 0.
  - rd_rsp_valid = 0, rd_rsp_data = 0, rd_rsp_err = 0, all rd_en = 0.
  - rd_req_ready is 1 once rstn deasserts.
  - In-flight and queued reads are dropped with no responses.
- rd_req_addr is sampled only on acc; it may change freely otherwise.

Test Plan:
- IMEM row 5 preloaded, bank 3 = 32'hDEAD_BEEF; request addr 14'h014C -> imem_rd_en with addr 5 at T; rsp_valid at T+2 with data 32'hDEAD_BEEF, err 0.
- OMEM word 1023 = 32'h1234_5678; request addr 14'h2FFC -> omem_rd_addr 10'h3FF; response 32'h1234_5678.
- Request addr 14'h3000 -> no rd_en asserted; response data 0, err 1; err_cnt goes 0 -> 1.
- 8 back-to-back requests WMEM rows 0..7, bank 0, with rd_rsp_ready = 1 -> rd_req_ready stays 1; 8 in-order responses on consecutive cycles starting at T+2.
- rd_rsp_ready = 0 with 4 requests issued -> exactly 2 accepted, then rd_req_ready = 0 and the head response is held stable; on releasing ready, remaining requests are accepted and all 4 responses return in order.
- Assert rstn low with 2 outstanding reads -> rsp_valid = 0 immediately; after release, no stale responses appear and rd_req_ready = 1.
